// File: rtl/rd_bus_dec_pkg.sv
// Register code map shared by the register read and write decoders,
// plus the read-decoder state encoding and a code-validity helper.
package rd_bus_dec_pkg;

    localparam int NSLOT = 23;

    localparam logic [4:0] CODE_R1   = 5'd1;
    localparam logic [4:0] CODE_R2   = 5'd2;
    localparam logic [4:0] CODE_R3   = 5'd3;
    localparam logic [4:0] CODE_R4   = 5'd4;
    localparam logic [4:0] CODE_R5   = 5'd5;
    localparam logic [4:0] CODE_R6   = 5'd6;
    localparam logic [4:0] CODE_R7   = 5'd7;
    localparam logic [4:0] CODE_R8   = 5'd8;
    localparam logic [4:0] CODE_R9   = 5'd9;
    localparam logic [4:0] CODE_R10  = 5'd10;
    localparam logic [4:0] CODE_R11  = 5'd11;
    localparam logic [4:0] CODE_R12  = 5'd12;
    localparam logic [4:0] CODE_R13  = 5'd13;
    localparam logic [4:0] CODE_R14  = 5'd14;
    localparam logic [4:0] CODE_TOTR = 5'd15;
    localparam logic [4:0] CODE_TR   = 5'd16;
    localparam logic [4:0] CODE_PC   = 5'd17;
    localparam logic [4:0] CODE_AR   = 5'd18;
    localparam logic [4:0] CODE_MDDR = 5'd21;
    localparam logic [4:0] CODE_IR   = 5'd22;
    localparam logic [4:0] CODE_ALL  = 5'd31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEL      = 2'd1,
        MEM_WAIT = 2'd2,
        DRIVE    = 2'd3
    } rd_state_t;

    // Readable codes: R1..AR contiguous, then MDDR and IR. The write
    // broadcast code (CODE_ALL) and the holes 19/20 are not readable.
    function automatic logic code_is_valid(input logic [4:0] code);
        logic v;
        v = ((code >= CODE_R1) && (code <= CODE_AR)) ||
            (code == CODE_MDDR) || (code == CODE_IR);
        return v;
    endfunction

endpackage

// File: rtl/rd_bus_dec_if.sv
// Read-decoder bus bundle: code sources, register bank view, memory
// fetch handshake and the read-bus results.
interface rd_bus_dec_if #(
    parameter int DW    = 16,
    parameter int NSLOT = 23
);
    logic [1:0]          RDSrc;
    logic [4:0]          MUX3D_out;
    logic [4:0]          RG2_out;
    logic [15:0]         TR_out;
    logic                rd_req;
    logic [NSLOT*DW-1:0] reg_flat;
    logic                mem_rd_ack;
    logic [DW-1:0]       mem_rd_data;
    logic [NSLOT-1:0]    RDDec_oe;
    logic [DW-1:0]       bus_data;
    logic                bus_valid;
    logic                rd_err;
    logic                busy;
    logic                mem_rd_req;

    modport slave (
        input  RDSrc, MUX3D_out, RG2_out, TR_out, rd_req, reg_flat,
               mem_rd_ack, mem_rd_data,
        output RDDec_oe, bus_data, bus_valid, rd_err, busy, mem_rd_req
    );

    modport master (
        output RDSrc, MUX3D_out, RG2_out, TR_out, rd_req, reg_flat,
               mem_rd_ack, mem_rd_data,
        input  RDDec_oe, bus_data, bus_valid, rd_err, busy, mem_rd_req
    );
endinterface

// File: rtl/rd_bus_dec_onehot.sv
// Combinational register code -> one-hot slot enable with validity flag.
// Invalid codes produce an all-zero enable.
module rd_bus_dec_onehot
    import rd_bus_dec_pkg::*;
#(
    parameter int NSLOT_P = NSLOT
) (
    input  logic [4:0]         code,
    output logic [NSLOT_P-1:0] onehot,
    output logic               code_valid
);

    // Decode the code into a single enable bit, gated by validity
    always_comb begin
        code_valid = code_is_valid(code);
        onehot     = '0;
        for (int k = 0; k < NSLOT_P; k++) begin
            onehot[k] = code_valid && (code == 5'(k));
        end
    end

endmodule

// File: rtl/rd_bus_dec.sv
// Register read-bus decoder: latches a register code from the selected
// source, raises the one-hot output enable for a cycle, then drives the
// register (or zero with rd_err for invalid codes) onto the read bus with
// a one-cycle bus_valid pulse.
// Optional feature macro: RDDEC_MEMFETCH_EN -- code 21 (MDDR) is fetched
// from memory through mem_rd_req/mem_rd_ack with a MEM_TO-cycle timeout.
module rd_bus_dec
    import rd_bus_dec_pkg::*;
#(
    parameter int DW      = 16,
    parameter int NSLOT_P = NSLOT,
    parameter int MEM_TO  = 15
) (
    input  logic         Clock,
    input  logic         Reset_n,
    rd_bus_dec_if.slave  bus
);

    rd_state_t            state_r, state_n;
    logic [4:0]           code_r, code_n;
    logic                 valid_r, valid_n;
    logic [NSLOT_P-1:0]   oe_r, oe_n;
    logic [DW-1:0]        data_r, data_n;
    logic                 bv_r, bv_n;
    logic                 err_r, err_n;
    logic                 busy_r, busy_n;
    logic                 memreq_r, memreq_n;
    logic [4:0]           sel_code_s;
    logic [NSLOT_P-1:0]   onehot_s;
    logic                 code_valid_s;
    logic [DW-1:0]        slot_s;

`ifdef RDDEC_MEMFETCH_EN
    localparam int CW = $clog2(MEM_TO + 1);
    logic [CW-1:0]        cnt_r, cnt_n;
    logic                 unused_s;
    assign unused_s = ^{bus.TR_out[15:5]};
`else
    logic                 unused_s;
    assign unused_s = ^{bus.TR_out[15:5], bus.mem_rd_ack, bus.mem_rd_data, 32'(MEM_TO)};
`endif

    // Pick the register code from the requested source
    always_comb begin
        sel_code_s = 5'd0;
        case (bus.RDSrc)
            2'd1:    sel_code_s = bus.MUX3D_out;
            2'd2:    sel_code_s = bus.RG2_out;
            2'd3:    sel_code_s = bus.TR_out[4:0];
            default: sel_code_s = 5'd0;
        endcase
    end

    rd_bus_dec_onehot #(.NSLOT_P(NSLOT_P)) u_onehot (
        .code       (sel_code_s),
        .onehot     (onehot_s),
        .code_valid (code_valid_s)
    );

    // Read the slot addressed by the latched code out of the flat bank
    always_comb begin
        slot_s = '0;
        for (int k = 0; k < NSLOT_P; k++) begin
            if (code_r == 5'(k)) begin
                slot_s = bus.reg_flat[k*DW +: DW];
            end else begin
                slot_s = slot_s;
            end
        end
    end

    // Next-state and next-output logic for the read sequence
    always_comb begin
        state_n  = state_r;
        code_n   = code_r;
        valid_n  = valid_r;
        oe_n     = oe_r;
        data_n   = data_r;
        bv_n     = 1'b0;
        err_n    = 1'b0;
        memreq_n = 1'b0;
`ifdef RDDEC_MEMFETCH_EN
        cnt_n    = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.rd_req && (bus.RDSrc != 2'd0)) begin
                    state_n = SEL;
                    code_n  = sel_code_s;
                    valid_n = code_valid_s;
                    oe_n    = onehot_s;
                end else begin
                    state_n = IDLE;
                end
            end
            SEL: begin
`ifdef RDDEC_MEMFETCH_EN
                if (code_r == CODE_MDDR) begin
                    state_n  = MEM_WAIT;
                    memreq_n = 1'b1;
                    cnt_n    = '0;
                end else begin
                    state_n = DRIVE;
                    oe_n    = '0;
                    bv_n    = 1'b1;
                    err_n   = !valid_r;
                    data_n  = valid_r ? slot_s : '0;
                end
`else
                state_n = DRIVE;
                oe_n    = '0;
                bv_n    = 1'b1;
                err_n   = !valid_r;
                data_n  = valid_r ? slot_s : '0;
`endif
            end
            MEM_WAIT: begin
`ifdef RDDEC_MEMFETCH_EN
                if (bus.mem_rd_ack) begin
                    state_n = DRIVE;
                    oe_n    = '0;
                    bv_n    = 1'b1;
                    data_n  = bus.mem_rd_data;
                end else if (cnt_r == CW'(MEM_TO - 1)) begin
                    state_n = DRIVE;
                    oe_n    = '0;
                    bv_n    = 1'b1;
                    err_n   = 1'b1;
                    data_n  = '0;
                end else begin
                    cnt_n    = cnt_r + CW'(1);
                    memreq_n = 1'b1;
                end
`else
                state_n = IDLE;
                oe_n    = '0;
`endif
            end
            DRIVE: begin
                state_n = IDLE;
                oe_n    = '0;
            end
            default: begin
                state_n = IDLE;
                oe_n    = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, code latch and registered outputs; reset aborts immediately
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_r  <= IDLE;
            code_r   <= 5'd0;
            valid_r  <= 1'b0;
            oe_r     <= '0;
            data_r   <= '0;
            bv_r     <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            memreq_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            code_r   <= code_n;
            valid_r  <= valid_n;
            oe_r     <= oe_n;
            data_r   <= data_n;
            bv_r     <= bv_n;
            err_r    <= err_n;
            busy_r   <= busy_n;
            memreq_r <= memreq_n;
        end
    end

`ifdef RDDEC_MEMFETCH_EN
    // Memory-wait cycle counter
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n;
        end
    end
`endif

    assign bus.RDDec_oe   = oe_r;
    assign bus.bus_data   = data_r;
    assign bus.bus_valid  = bv_r;
    assign bus.rd_err     = err_r;
    assign bus.busy       = busy_r;
    assign bus.mem_rd_req = memreq_r;

endmodule

// File: tb/tb_rd_bus_dec.sv
// Directed self-checking bench for rd_bus_dec (default build; the memory
// fetch section is compiled only with RDDEC_MEMFETCH_EN).
module tb_rd_bus_dec;

    logic Clock;
    logic Reset_n;
    int   checks;
    int   errors;
    int   pulses;

    rd_bus_dec_if #(.DW(16), .NSLOT(23)) bus ();

    rd_bus_dec #(.DW(16), .NSLOT_P(23), .MEM_TO(15)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_read(input logic [1:0] src, input logic [4:0] code);
        bus.RDSrc     = src;
        bus.MUX3D_out = code;
        bus.RG2_out   = code;
        bus.TR_out    = {11'h000, code};
        bus.rd_req    = 1'b1;
        tick();
        bus.rd_req    = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_oe"},     32'(bus.RDDec_oe),   32'h0);
        chk({tag, "_valid"},  32'(bus.bus_valid),  32'h0);
        chk({tag, "_err"},    32'(bus.rd_err),     32'h0);
        chk({tag, "_busy"},   32'(bus.busy),       32'h0);
        chk({tag, "_memreq"}, 32'(bus.mem_rd_req), 32'h0);
    endtask

    initial begin
        logic [7:0] bv_pat;
        logic [7:0] busy_pat;
        checks = 0;
        errors = 0;
        pulses = 0;
        Reset_n         = 1'b0;
        bus.RDSrc       = 2'd0;
        bus.MUX3D_out   = 5'd0;
        bus.RG2_out     = 5'd0;
        bus.TR_out      = 16'h0000;
        bus.rd_req      = 1'b0;
        bus.mem_rd_ack  = 1'b0;
        bus.mem_rd_data = 16'h0000;
        for (int k = 0; k < 23; k++) begin
            bus.reg_flat[k*16 +: 16] = 16'h1000 + 16'(k);
        end
        bus.reg_flat[5*16 +: 16]  = 16'hA5A5;
        bus.reg_flat[17*16 +: 16] = 16'h0100;
        bus.reg_flat[3*16 +: 16]  = 16'h0333;
        bus.reg_flat[21*16 +: 16] = 16'h2121;

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        chk("reset_data", 32'(bus.bus_data), 32'h0);
        Reset_n = 1'b1;
        tick();

        // RG2 source, code 5
        start_read(2'd2, 5'd5);
        chk("r5_sel_oe",   32'(bus.RDDec_oe),  32'h0000_0020);
        chk("r5_sel_busy", 32'(bus.busy),      32'h1);
        chk("r5_sel_bv",   32'(bus.bus_valid), 32'h0);
        bus.RG2_out = 5'd7;
        tick();
        chk("r5_bv",   32'(bus.bus_valid), 32'h1);
        chk("r5_data", 32'(bus.bus_data),  32'h0000_A5A5);
        chk("r5_err",  32'(bus.rd_err),    32'h0);
        chk("r5_oe",   32'(bus.RDDec_oe),  32'h0);
        tick();
        chk("r5_bv_end",   32'(bus.bus_valid), 32'h0);
        chk("r5_busy_end", 32'(bus.busy),      32'h0);

        // TR source, PC code
        start_read(2'd3, 5'd17);
        chk("pc_sel_oe", 32'(bus.RDDec_oe), 32'h0002_0000);
        tick();
        chk("pc_bv",   32'(bus.bus_valid), 32'h1);
        chk("pc_data", 32'(bus.bus_data),  32'h0000_0100);
        chk("pc_err",  32'(bus.rd_err),    32'h0);
        tick();

        // Invalid code 19
        start_read(2'd1, 5'd19);
        chk("c19_sel_oe",   32'(bus.RDDec_oe), 32'h0);
        chk("c19_sel_busy", 32'(bus.busy),     32'h1);
        tick();
        chk("c19_bv",   32'(bus.bus_valid), 32'h1);
        chk("c19_data", 32'(bus.bus_data),  32'h0);
        chk("c19_err",  32'(bus.rd_err),    32'h1);
        tick();
        chk("c19_err_end", 32'(bus.rd_err), 32'h0);

        // Broadcast code 31 is not readable
        start_read(2'd1, 5'd31);
        chk("c31_sel_oe", 32'(bus.RDDec_oe), 32'h0);
        tick();
        chk("c31_bv",   32'(bus.bus_valid), 32'h1);
        chk("c31_err",  32'(bus.rd_err),    32'h1);
        chk("c31_data", 32'(bus.bus_data),  32'h0);
        tick();

        // No source selected: request ignored
        bus.RDSrc  = 2'd0;
        bus.rd_req = 1'b1;
        tick();
        chk("nosrc_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("nosrc_bv",   32'(bus.bus_valid), 32'h0);
        chk("nosrc_busy2", 32'(bus.busy),     32'h0);
        bus.rd_req = 1'b0;
        tick();

        // rd_req held for 6 edges, code 3: two reads 3 cycles apart
        bv_pat   = 8'b0001_0010;
        busy_pat = 8'b0001_1011;
        bus.RDSrc     = 2'd1;
        bus.MUX3D_out = 5'd3;
        bus.rd_req    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 5) bus.rd_req = 1'b0;
            chk($sformatf("b2b_bv_%0d", i),   32'(bus.bus_valid), 32'(bv_pat[i]));
            chk($sformatf("b2b_busy_%0d", i), 32'(bus.busy),      32'(busy_pat[i]));
            if (bus.bus_valid) begin
                pulses++;
                chk($sformatf("b2b_data_%0d", i), 32'(bus.bus_data), 32'h0000_0333);
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);

`ifndef RDDEC_MEMFETCH_EN
        // MDDR reads its register slot; memory request never raised
        start_read(2'd2, 5'd21);
        chk("mddr_sel_oe",  32'(bus.RDDec_oe),   32'h0020_0000);
        chk("mddr_memreq0", 32'(bus.mem_rd_req), 32'h0);
        tick();
        chk("mddr_bv",     32'(bus.bus_valid),  32'h1);
        chk("mddr_data",   32'(bus.bus_data),   32'h0000_2121);
        chk("mddr_err",    32'(bus.rd_err),     32'h0);
        chk("mddr_memreq", 32'(bus.mem_rd_req), 32'h0);
        tick();

        // Reset during SEL aborts the read
        start_read(2'd2, 5'd5);
        chk("rst_pre_busy", 32'(bus.busy), 32'h1);
        Reset_n = 1'b0;
        tick();
        check_idle_outputs("rst_mid");
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_after_bv_%0d", i), 32'(bus.bus_valid), 32'h0);
        end
`else
        // Memory fetch with ack after 4 wait cycles
        start_read(2'd2, 5'd21);
        chk("mf_sel_oe", 32'(bus.RDDec_oe), 32'h0020_0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mf_req_%0d", i), 32'(bus.mem_rd_req), 32'h1);
            chk($sformatf("mf_oe_%0d", i),  32'(bus.RDDec_oe),   32'h0020_0000);
            tick();
        end
        bus.mem_rd_ack  = 1'b1;
        bus.mem_rd_data = 16'hBEEF;
        tick();
        bus.mem_rd_ack = 1'b0;
        chk("mf_bv",     32'(bus.bus_valid),  32'h1);
        chk("mf_data",   32'(bus.bus_data),   32'h0000_BEEF);
        chk("mf_err",    32'(bus.rd_err),     32'h0);
        chk("mf_req_lo", 32'(bus.mem_rd_req), 32'h0);
        tick();

        // Memory fetch timeout after 15 wait cycles
        start_read(2'd2, 5'd21);
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("to_wait_bv_%0d", i), 32'(bus.bus_valid), 32'h0);
            chk($sformatf("to_req_%0d", i),     32'(bus.mem_rd_req), 32'h1);
        end
        tick();
        chk("to_bv",     32'(bus.bus_valid),  32'h1);
        chk("to_err",    32'(bus.rd_err),     32'h1);
        chk("to_data",   32'(bus.bus_data),   32'h0);
        chk("to_req_lo", 32'(bus.mem_rd_req), 32'h0);
        tick();

        // Reset during MEM_WAIT
        start_read(2'd2, 5'd21);
        tick();
        chk("rst_pre_req", 32'(bus.mem_rd_req), 32'h1);
        Reset_n = 1'b0;
        tick();
        check_idle_outputs("rst_mid");
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_after_bv_%0d", i), 32'(bus.bus_valid), 32'h0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
